// File: rtl/cache_ram_port_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cache_ram_port_ctrl_if                                          |
// | Brief    : Cache-pipeline side of the RAM port controller: fire-and-forget |
// |            write, valid/ready read request and read response channels.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface cache_ram_port_ctrl_if #(
    parameter int LEN_DATA = 32,
    parameter int LEN_ADDR = 10
);
    logic                  wr_valid;
    logic [LEN_ADDR-1:0]   wr_addr;
    logic [LEN_DATA/8-1:0] wr_strb;
    logic [LEN_DATA-1:0]   wr_data;

    logic                  rd_valid;
    logic                  rd_ready;
    logic [LEN_ADDR-1:0]   rd_addr;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [LEN_DATA-1:0]   rsp_rdata;

    modport master (
        output wr_valid, wr_addr, wr_strb, wr_data,
        output rd_valid, rd_addr, rsp_ready,
        input  rd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  wr_valid, wr_addr, wr_strb, wr_data,
        input  rd_valid, rd_addr, rsp_ready,
        output rd_ready, rsp_valid, rsp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/cache_ram_port_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cache_ram_port_ctrl                                             |
// | Brief    : Drives a simple dual-port byte-enabled cache RAM; in-order read |
// |            responses with credit-based backpressure. Define macro          |
// |            CACHE_RAM_PORT_FWD_EN to merge same-cycle write data into reads.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module cache_ram_port_ctrl #(
    parameter int LEN_DATA  = 32,
    parameter int LEN_ADDR  = 10,
    parameter int RSP_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_ram_port_ctrl_if.slave  bus,
    output logic                  ram_ena,
    output logic [LEN_DATA/8-1:0] ram_wea,
    output logic [LEN_ADDR-1:0]   ram_addra,
    output logic [LEN_DATA-1:0]   ram_dina,
    output logic                  ram_enb,
    output logic [LEN_ADDR-1:0]   ram_addrb,
    input  logic [LEN_DATA-1:0]   ram_doutb
);
    localparam int STRB_W = LEN_DATA / 8;
    localparam int PTR_W  = (RSP_DEPTH > 2) ? 2 : 1;
    localparam int CNT_W  = 3;

    logic                 rd_fire;
    logic                 pop;
    logic                 push;
    logic                 deq;
    logic                 occ_nz;
    logic [CNT_W:0]       credit;
    logic [LEN_DATA-1:0]  beat_data;

    logic [CNT_W-1:0]     occ_q,  occ_d;
    logic                 infl_q, infl_d;
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [LEN_DATA-1:0]  fifo_q [RSP_DEPTH];
    logic [LEN_DATA-1:0]  fifo_d [RSP_DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        ram_ena   = bus.wr_valid & ~rst;
        ram_wea   = bus.wr_valid ? bus.wr_strb : '0;
        ram_addra = bus.wr_addr;
        ram_dina  = bus.wr_data;
    end

`ifdef CACHE_RAM_PORT_FWD_EN
    logic [STRB_W-1:0]   mask_q,  mask_d;
    logic [LEN_DATA-1:0] wdata_q, wdata_d;
    logic [LEN_DATA-1:0] mask_bits;

    // RAM port B is read-first, so a colliding write is patched into the beat here.
    always_comb begin
        mask_d  = '0;
        wdata_d = wdata_q;
        if (rd_fire && bus.wr_valid && (bus.rd_addr == bus.wr_addr)) begin
            mask_d  = bus.wr_strb;
            wdata_d = bus.wr_data;
        end
        mask_bits = '0;
        for (int i = 0; i < STRB_W; i++) begin
            mask_bits[8*i +: 8] = {8{mask_q[i]}};
        end
        beat_data = (ram_doutb & ~mask_bits) | (wdata_q & mask_bits);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
        wdata_q <= wdata_d;
    end
`else
    always_comb begin
        beat_data = ram_doutb;
    end
`endif

    always_comb begin
        occ_nz        = (occ_q != '0);
        bus.rsp_valid = ~rst & (occ_nz | infl_q);
        bus.rsp_rdata = occ_nz ? fifo_q[head_q] : beat_data;
        pop           = bus.rsp_valid & bus.rsp_ready;

        // Outstanding responses after this cycle's pop must leave room for one more.
        credit        = {1'b0, occ_q} + (CNT_W+1)'(infl_q) - (CNT_W+1)'(pop);
        bus.rd_ready  = ~rst & (credit < (CNT_W+1)'(RSP_DEPTH));
        rd_fire       = bus.rd_valid & bus.rd_ready;
        ram_enb       = rd_fire;
        ram_addrb     = bus.rd_addr;

        deq    = pop & occ_nz;
        push   = infl_q & ~(pop & ~occ_nz);
        infl_d = rd_fire;
        occ_d  = occ_q + CNT_W'(push) - CNT_W'(deq);
        head_d = deq  ? ptr_inc(head_q) : head_q;
        tail_d = push ? ptr_inc(tail_q) : tail_q;

        fifo_d = fifo_q;
        if (push) begin
            fifo_d[tail_q] = beat_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= '0;
            infl_q <= 1'b0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            infl_q <= infl_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end
endmodule
`default_nettype wire
